// File: rtl/vending_fsm_change.sv
// ---------------------------------------------------------------------------
// vending_fsm_change
//
// Coin-operated vending controller. Accepts coins of several values, vends
// once the accumulated credit reaches PRICE, returns any excess (or the whole
// credit on refund) as a train of single-unit change pulses, and keeps a
// saturating count of vends.
//
// Ports:
//   sys_clk         clock
//   sys_rst_n       asynchronous, active-low reset
//   coin_valid      coin inserted this cycle (one-cycle strobe)
//   coin_val        coin value in units, qualified by coin_valid
//   refund_request  refund button level, sampled every cycle
//   cola            one-cycle vend pulse
//   refund          one-cycle pulse: refund accepted
//   change_pulse    one pulse per returned unit of change
//   coin_reject     one-cycle pulse: sampled coin not accepted
//   busy            high while change is being returned
//   credit          current credit in units
//   vend_count      vends since reset, saturating at all-ones
//
// Every output is a register (or a direct decode of the state register), so
// an input sampled on one edge shows its effect in the following cycle.
// ---------------------------------------------------------------------------
module vending_fsm_change #(
  parameter int PRICE  = 3,
  parameter int VAL_W  = 2,
  parameter int CRED_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              coin_valid,
  input  logic [VAL_W-1:0]  coin_val,
  input  logic              refund_request,
  output logic              cola,
  output logic              refund,
  output logic              change_pulse,
  output logic              coin_reject,
  output logic              busy,
  output logic [CRED_W-1:0] credit,
  output logic [CNT_W-1:0]  vend_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHANGE  = 2'd2
  } state_t;

  // Price at the width of the coin sum, so the compare cannot wrap.
  localparam logic [CRED_W:0] PRICE_EXT = (CRED_W+1)'(PRICE);

  state_t            state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]  vend_q, vend_d;
  logic              cola_q, refund_q, change_q, reject_q;
  logic              cola_d, refund_d, change_d, reject_d;

  logic              coin_live;
  logic              refund_take;
  logic [CRED_W:0]   sum;
  logic [CRED_W:0]   remainder;
  logic              price_met;

  // A zero-value coin is treated as no coin at all.
  assign coin_live   = coin_valid && (coin_val != '0);
  // Refund is only honoured while credit is partially collected.
  assign refund_take = (state_q == S_COLLECT) && refund_request;
  assign sum         = {1'b0, credit_q} + {{(CRED_W+1-VAL_W){1'b0}}, coin_val};
  assign remainder   = sum - PRICE_EXT;
  assign price_met   = (sum >= PRICE_EXT);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      vend_q   <= '0;
      cola_q   <= 1'b0;
      refund_q <= 1'b0;
      change_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational processes.
      state_q  <= state_d;
      credit_q <= credit_d;
      vend_q   <= vend_d;
      cola_q   <= cola_d;
      refund_q <= refund_d;
      change_q <= change_d;
      reject_q <= reject_d;
    end
  end

  // Next-state logic: state, credit and sales count
  always_comb begin
    // NOTE: hold-value defaults first, so no path leaves a signal unassigned
    // and no latch is inferred.
    state_d  = state_q;
    credit_d = credit_q;
    vend_d   = vend_q;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (refund_take) begin
          state_d = S_CHANGE;
        end else if (coin_live) begin
          if (!price_met) begin
            credit_d = sum[CRED_W-1:0];
            state_d  = S_COLLECT;
          end else begin
            credit_d = remainder[CRED_W-1:0];
            state_d  = (remainder != '0) ? S_CHANGE : S_IDLE;
            if (vend_q != '1) vend_d = vend_q + CNT_W'(1);
          end
        end
      end
      S_CHANGE: begin
        // A zero credit here cannot occur; it is folded into the last-unit
        // case so the machine can never spin in CHANGE.
        if (credit_q <= CRED_W'(1)) begin
          credit_d = '0;
          state_d  = S_IDLE;
        end else begin
          credit_d = credit_q - CRED_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Output logic: next values of the one-cycle event pulses
  always_comb begin
    cola_d   = 1'b0;
    refund_d = 1'b0;
    change_d = 1'b0;
    reject_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (refund_take) begin
          refund_d = 1'b1;
          reject_d = coin_live;  // refund wins over a simultaneous coin
        end else if (coin_live && price_met) begin
          cola_d = 1'b1;
        end
      end
      S_CHANGE: begin
        change_d = (credit_q != '0);
        reject_d = coin_live;
      end
      default: ;
    endcase
  end

  assign cola         = cola_q;
  assign refund       = refund_q;
  assign change_pulse = change_q;
  assign coin_reject  = reject_q;
  assign busy         = (state_q == S_CHANGE);
  assign credit       = credit_q;
  assign vend_count   = vend_q;

endmodule

// File: tb/tb_vending_fsm_change.sv
// ---------------------------------------------------------------------------
// tb_vending_fsm_change
//
// Directed bench for vending_fsm_change (PRICE=3, VAL_W=2, CRED_W=4, CNT_W=8)
// plus a CNT_W=2 instance sharing the same stimulus for counter saturation.
// Expected event records are queued by the stimulus; a monitor pops one and
// compares whenever the DUT raises any event pulse.
// ---------------------------------------------------------------------------
module tb_vending_fsm_change;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_val = '0;
  logic       refund_request = 1'b0;

  logic       cola, refund, change_pulse, coin_reject, busy;
  logic [3:0] credit;
  logic [7:0] vend_count;

  logic       cola2, refund2, change_pulse2, coin_reject2, busy2;
  logic [3:0] credit2;
  logic [1:0] vend_count2;

  typedef struct packed {
    logic       cola;
    logic       refund;
    logic       change_pulse;
    logic       coin_reject;
    logic       busy;
    logic [3:0] credit;
    logic [7:0] vend_count;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 sys_clk = ~sys_clk;

  vending_fsm_change #(.PRICE(3), .VAL_W(2), .CRED_W(4), .CNT_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .coin_valid(coin_valid),
    .coin_val(coin_val), .refund_request(refund_request), .cola(cola),
    .refund(refund), .change_pulse(change_pulse), .coin_reject(coin_reject),
    .busy(busy), .credit(credit), .vend_count(vend_count)
  );

  vending_fsm_change #(.PRICE(3), .VAL_W(2), .CRED_W(4), .CNT_W(2)) dut_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .coin_valid(coin_valid),
    .coin_val(coin_val), .refund_request(refund_request), .cola(cola2),
    .refund(refund2), .change_pulse(change_pulse2), .coin_reject(coin_reject2),
    .busy(busy2), .credit(credit2), .vend_count(vend_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic c, input logic r, input logic cp, input logic rj,
                      input logic b, input logic [3:0] cr, input logic [7:0] vc);
    exp_q.push_back(obs_t'({c, r, cp, rj, b, cr, vc}));
  endtask

  // One cycle of stimulus: inputs applied, sampled at the next edge, then cleared.
  task automatic drive(input logic v, input logic [1:0] val, input logic rr);
    coin_valid     = v;
    coin_val       = val;
    refund_request = rr;
    @(posedge sys_clk);
    #1;
    coin_valid     = 1'b0;
    coin_val       = '0;
    refund_request = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_credit"}, credit, 0);
  endtask

  // Monitor: every event pulse must match the oldest queued expectation.
  initial begin
    obs_t obs;
    forever begin
      @(negedge sys_clk);
      if (cola || refund || change_pulse || coin_reject) begin
        obs = obs_t'({cola, refund, change_pulse, coin_reject, busy, credit, vend_count});
        if (exp_q.size() == 0) check("unexpected_event", obs, '0);
        else                   check("event", obs, exp_q.pop_front());
      end
    end
  end

  initial begin
    // 1: reset state and idle
    do_reset();
    check("rst_outputs", {cola, refund, change_pulse, coin_reject, busy}, '0);
    idle(10);
    check("idle_cola", cola, 0);
    check("idle_change_pulse", change_pulse, 0);
    check("idle_busy", busy, 0);
    check("idle_credit", credit, 0);
    check("idle_vend_count", vend_count, 0);

    // 2: three 1-unit coins, exact price
    do_reset();
    drive(1'b1, 2'd1, 1'b0);
    check("t2_credit1", credit, 1);
    idle(1);
    drive(1'b1, 2'd1, 1'b0);
    check("t2_credit2", credit, 2);
    idle(1);
    push(1, 0, 0, 0, 0, 4'd0, 8'd1);
    drive(1'b1, 2'd1, 1'b0);
    idle(3);
    check_quiet("t2");
    check("t2_vend_count", vend_count, 1);

    // 3: coin 2 then coin 3 -> vend plus two units of change
    do_reset();
    drive(1'b1, 2'd2, 1'b0);
    push(1, 0, 0, 0, 1, 4'd2, 8'd1);
    push(0, 0, 1, 0, 1, 4'd1, 8'd1);
    push(0, 0, 1, 0, 0, 4'd0, 8'd1);
    drive(1'b1, 2'd3, 1'b0);
    idle(4);
    check_quiet("t3");
    check("t3_vend_count", vend_count, 1);

    // 4: coin 2 then refund
    do_reset();
    drive(1'b1, 2'd2, 1'b0);
    push(0, 1, 0, 0, 1, 4'd2, 8'd0);
    push(0, 0, 1, 0, 1, 4'd1, 8'd0);
    push(0, 0, 1, 0, 0, 4'd0, 8'd0);
    drive(1'b0, 2'd0, 1'b1);
    idle(4);
    check_quiet("t4");
    check("t4_vend_count", vend_count, 0);

    // 5: refund beats coin; coin during CHANGE rejected
    do_reset();
    drive(1'b1, 2'd1, 1'b0);
    push(0, 1, 0, 1, 1, 4'd1, 8'd0);
    drive(1'b1, 2'd3, 1'b1);
    push(0, 0, 1, 1, 0, 4'd0, 8'd0);
    drive(1'b1, 2'd2, 1'b0);
    idle(4);
    check_quiet("t5");

    // Zero-value coin and refund in IDLE are ignored
    drive(1'b1, 2'd0, 1'b0);
    check("zero_coin_credit", credit, 0);
    drive(1'b0, 2'd0, 1'b1);
    idle(2);
    check_quiet("t5b");

    // Saturation: five vends on the CNT_W=2 instance stop at 3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(1, 0, 0, 0, 0, 4'd0, 8'(i + 1));
      drive(1'b1, 2'd3, 1'b0);
      idle(1);
    end
    check("sat_vend_count2", vend_count2, 3);
    check("sat_vend_count", vend_count, 5);
    check_quiet("sat");

    // 6: reset asserted during CHANGE with credit 2
    do_reset();
    drive(1'b1, 2'd2, 1'b0);
    push(1, 0, 0, 0, 1, 4'd2, 8'd1);
    drive(1'b1, 2'd3, 1'b0);
    @(negedge sys_clk);
    #1;
    check("t6_busy_before", busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_pulses", {cola, refund, change_pulse, coin_reject, busy}, '0);
    check("t6_rst_credit", credit, 0);
    check("t6_rst_vend_count", vend_count, 0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    idle(5);
    check_quiet("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
